// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect/halt
// control from downstream, and the instruction handshake to decode.
// master = fetch unit side, slave = memory/decode/control side.
interface ifetch_unit_if;
  // instruction memory
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  // control from downstream
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  // decode handshake
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, halt, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, halt, instr_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time,
// buffers up to two {instr, pc} entries for decode, handles redirect/halt.
// Optional feature: define IFETCH_BYPASS_EN to forward a response straight to
// decode in the same cycle when the buffer is empty.
module ifetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic           clk,
  input logic           rst,
  ifetch_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWait, StSquash, StHalted} state_e;

  state_e            state_q;
  logic [15:0]       fetch_pc_q;
  logic [15:0]       req_pc_q;    // address of the outstanding request
  logic [1:0][15:0]  fifo_instr_q;
  logic [1:0][15:0]  fifo_pc_q;
  logic              head_q;
  logic [1:0]        count_q;

  logic xfer;
  logic fifo_valid;
  logic fifo_pop;
  logic tail;
  logic rsp_push;
  logic byp_hit;
  logic byp_take;
  logic push;

  // Request issue, decode-facing outputs and FIFO control
  always_comb begin
    // rst gates the request so memory sees nothing while reset is held
    bus.imem_req  = !rst && (state_q == StIdle) && (count_q != 2'd2);
    bus.imem_addr = fetch_pc_q;
    xfer          = bus.imem_req & bus.imem_ready;

    fifo_valid = (count_q != 2'd0);
    tail       = head_q ^ count_q[0];
    rsp_push   = (state_q == StWait) && bus.imem_rvalid && !bus.redirect && !bus.halt;

`ifdef IFETCH_BYPASS_EN
    byp_hit = (count_q == 2'd0) && rsp_push;
`else
    byp_hit = 1'b0;
`endif

    bus.instr_valid = fifo_valid | byp_hit;
    bus.instr       = byp_hit ? bus.imem_rdata : fifo_instr_q[head_q];
    bus.instr_pc    = byp_hit ? req_pc_q : fifo_pc_q[head_q];
    bus.halted      = (state_q == StHalted);

    fifo_pop = fifo_valid & bus.instr_ready;
    byp_take = byp_hit & bus.instr_ready;
    push     = rsp_push & !byp_take;
  end

  // FSM, PC and instruction buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      fifo_instr_q <= '0;
      fifo_pc_q    <= '0;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
    end else if (state_q == StHalted) begin
      // only rst leaves this state
      state_q <= StHalted;
    end else if (bus.redirect) begin
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      fetch_pc_q <= bus.redirect_pc;
      // a request accepted or still in flight must have its response dropped
      unique case (state_q)
        StIdle:             state_q <= xfer ? StSquash : StIdle;
        StWait, StSquash:   state_q <= bus.imem_rvalid ? StIdle : StSquash;
        StHalted:           state_q <= StHalted;
      endcase
    end else if (bus.halt) begin
      // outstanding response is ignored in StHalted
      count_q <= 2'd0;
      head_q  <= 1'b0;
      state_q <= StHalted;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + 16'd1;
            state_q    <= StWait;
          end
        end
        StWait, StSquash: begin
          if (bus.imem_rvalid) state_q <= StIdle;
        end
        StHalted: state_q <= StHalted;
      endcase
      // tail slot is always free: a push only follows an issue made with count < 2
      if (push) begin
        fifo_instr_q[tail] <= bus.imem_rdata;
        fifo_pc_q[tail]    <= req_pc_q;
      end
      head_q  <= head_q ^ fifo_pop;
      count_q <= count_q + {1'b0, push} - {1'b0, fifo_pop};
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a behavioural memory plus a stream model (expected
// next request address and next delivered pc) checks every transfer and pop.
module tb_ifetch_unit;

  localparam logic [15:0] ResetPc = 16'h0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(ResetPc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // stimulus knobs
  int unsigned mem_rdy_pct = 100;
  int unsigned lat_min = 0, lat_max = 0;
  int unsigned dec_rdy_pct = 100;
  int unsigned redir_pct = 0;
  int          f_dec = -1;   // -1 random, 0/1 forced instr_ready
  bit          f_redir = 0;
  logic [15:0] f_redir_pc = '0;
  bit          f_halt = 0;

  // reference model
  logic [15:0] exp_req, exp_del;
  bit          m_halted;
  bit          pend;
  int unsigned pend_dly;
  logic [15:0] pend_addr;

  // last-cycle samples and counters
  bit          s_xfer, s_pop, s_rvalid, s_valid, s_req;
  logic [15:0] s_addr, s_pc;
  int unsigned n_del = 0, n_xfer = 0;

  // One cycle: drive at the negedge, sample 1 time unit later, advance to next negedge
  task automatic step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 16'($urandom);
    if (pend) begin
      if (pend_dly == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pend_addr ^ 16'hA000;
        pend            = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    bus.imem_ready  = ($urandom_range(99) < mem_rdy_pct);
    bus.instr_ready = (f_dec >= 0) ? (f_dec == 1) : ($urandom_range(99) < dec_rdy_pct);
    bus.redirect    = f_redir || ($urandom_range(99) < redir_pct);
    bus.redirect_pc = f_redir ? f_redir_pc : 16'($urandom);
    bus.halt        = f_halt;
    #1;
    s_req    = bus.imem_req;
    s_addr   = bus.imem_addr;
    s_xfer   = bus.imem_req & bus.imem_ready;
    s_rvalid = bus.imem_rvalid;
    s_valid  = bus.instr_valid;
    s_pc     = bus.instr_pc;
    s_pop    = bus.instr_valid & bus.instr_ready;

    if (m_halted) begin
      check_eq("halted_flag", bus.halted, 1);
      check_eq("halted_req", bus.imem_req, 0);
      check_eq("halted_valid", bus.instr_valid, 0);
    end
    if (s_xfer) begin
      check_eq("req_addr", s_addr, exp_req);
      check_eq("one_outstanding", pend, 0);
      pend      = 1'b1;
      pend_addr = s_addr;
      pend_dly  = $urandom_range(lat_max, lat_min);
      n_xfer++;
    end
    if (s_pop) begin
      check_eq("instr_pc", s_pc, exp_del);
      check_eq("instr_word", bus.instr, exp_del ^ 16'hA000);
      n_del++;
    end

    if (!m_halted) begin
      if (bus.redirect) begin
        exp_req = bus.redirect_pc;
        exp_del = bus.redirect_pc;
      end else begin
        if (s_xfer) exp_req = exp_req + 16'd1;
        if (s_pop)  exp_del = exp_del + 16'd1;
        if (bus.halt) m_halted = 1'b1;
      end
    end
    f_redir = 1'b0;
    f_halt  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt        = 1'b0;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_req", bus.imem_req, 0);
    check_eq("rst_addr", bus.imem_addr, ResetPc);
    check_eq("rst_valid", bus.instr_valid, 0);
    check_eq("rst_instr", bus.instr, 0);
    check_eq("rst_instr_pc", bus.instr_pc, 0);
    check_eq("rst_halted", bus.halted, 0);
    @(negedge clk);
    rst      = 1'b0;
    exp_req  = ResetPc;
    exp_del  = ResetPc;
    m_halted = 1'b0;
    pend     = 1'b0;
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    f_redir    = 1'b1;
    f_redir_pc = pc;
    step();
  endtask

  // Run until a transfer to addr is seen (bounded); found reports success
  task automatic wait_xfer(input logic [15:0] addr, output bit found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (s_xfer && s_addr == addr) found = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0, x0;
    bit found, seen_ffff, seen_0000, byp_done;

    @(negedge clk);
    do_reset();

    // 1-cycle memory, decode always ready: sequential stream from RESET_PC
    mem_rdy_pct = 100; lat_min = 0; lat_max = 0; dec_rdy_pct = 100; redir_pct = 0; f_dec = -1;
    d0 = n_del;
    step();
    check_eq("first_req", s_req, 1);
    check_eq("first_addr", s_addr, ResetPc);
    repeat (11) step();
    check_eq("stream_rate", (n_del - d0) >= 5, 1);

    // decode stalled: buffer fills with exactly two requests
    f_dec = 0;
    redirect_to(16'h0000);
    x0 = n_xfer;
    repeat (10) step();
    check_eq("stall_req_count", n_xfer - x0, 2);
    check_eq("stall_req_low", s_req, 0);
    check_eq("stall_head_valid", s_valid, 1);
    check_eq("stall_head_pc", s_pc, 16'h0000);
    f_dec = 1;
    d0 = n_del;
    repeat (10) step();
    check_eq("stall_drain", (n_del - d0) >= 3, 1);

    // redirect while waiting on addr 5
    lat_min = 2; lat_max = 2;
    redirect_to(16'h0005);
    wait_xfer(16'h0005, found);
    check_eq("wait5_found", found, 1);
    redirect_to(16'h0100);
    step();
    check_eq("wait5_flushed", s_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_pop) begin
        found = 1'b1;
        check_eq("wait5_first_pc", s_pc, 16'h0100);
      end
    end
    check_eq("wait5_delivered", found, 1);

    // redirect coincident with rvalid and a pop
    lat_min = 0; lat_max = 0; f_dec = 0;
    redirect_to(16'h0040);
    wait_xfer(16'h0041, found);
    check_eq("rdpop_setup", found, 1);
    f_dec = 1;
    redirect_to(16'h0200);
    check_eq("rdpop_rvalid", s_rvalid, 1);
    check_eq("rdpop_pop", s_pop, 1);
    check_eq("rdpop_pop_pc", s_pc, 16'h0040);
    d0 = n_del;
    repeat (10) step();
    check_eq("rdpop_resume", (n_del - d0) >= 3, 1);

    // halt with one buffered and one outstanding
    lat_min = 2; lat_max = 2; f_dec = 0;
    redirect_to(16'h0300);
    wait_xfer(16'h0301, found);
    check_eq("halt_setup", found, 1);
    check_eq("halt_buffered", s_valid, 1);
    f_halt = 1'b1;
    step();
    x0 = n_xfer;
    mem_rdy_pct = 50; f_dec = -1; dec_rdy_pct = 50;
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 2) begin
        f_redir    = 1'b1;
        f_redir_pc = 16'h0777;
      end
      step();
    end
    check_eq("halt_no_req", n_xfer - x0, 0);
    do_reset();

    // PC wrap and response-to-decode latency
    mem_rdy_pct = 100; lat_min = 0; lat_max = 0; dec_rdy_pct = 100; f_dec = -1;
    redirect_to(16'hFFFF);
    seen_ffff = 0; seen_0000 = 0; byp_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!byp_done && seen_ffff && s_rvalid) begin
`ifdef IFETCH_BYPASS_EN
        check_eq("bypass_valid", s_valid, 1);
`else
        check_eq("registered_valid", s_valid, 0);
`endif
        byp_done = 1;
      end
      if (s_xfer && s_addr == 16'hFFFF) seen_ffff = 1;
      if (s_xfer && s_addr == 16'h0000 && seen_ffff) seen_0000 = 1;
    end
    check_eq("wrap_seen", seen_0000, 1);
    check_eq("wrap_rvalid_seen", byp_done, 1);

    // randomized traffic with occasional redirects
    mem_rdy_pct = 70; lat_min = 0; lat_max = 3; dec_rdy_pct = 60; redir_pct = 3; f_dec = -1;
    d0 = n_del;
    repeat (1500) step();
    check_eq("random_progress", (n_del - d0) > 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

- Instruction fetch stage of the 16-bit CPU; sits directly upstream of the opcode decoder/control block.
- Owns the program counter and issues word reads to instruction memory over a valid/ready request, in-order response interface.
- Buffers up to two fetched instructions in a small queue and presents them to decode with a valid/ready handshake.
- Handles branch redirects (flush and refetch) and the HALT stop condition.

## Interface

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset (word address)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  16  fetch word address
- imem_ready  in  1  memory accepts request this cycle (transfer = imem_req & imem_ready)
- imem_rvalid  in  1  read data valid; in order, at most one response per accepted request
- imem_rdata  in  16  instruction word
- redirect  in  1  branch/jump taken, resolved downstream
- redirect_pc  in  16  new fetch address
- halt  in  1  decode saw HALT (control's pc_write low)
- instr_valid  out  1  instr/instr_pc valid to decode
- instr_ready  in  1  decode consumes this cycle
- instr  out  16  instruction word; opcode = instr[15:12]
- instr_pc  out  16  address of instr
- halted  out  1  fetch stopped by halt

## Operation

- Holds fetch_pc, a 2-entry FIFO of {instr, pc}, count 0..2, and FSM state.
- FSM states:
  - IDLE: drives imem_req=1 when count<2; on transfer: fetch_pc+=1 (mod 2^16, FFFF wraps to 0000), go WAIT.
  - WAIT: imem_req=0; on imem_rvalid push {imem_rdata, address of request}, go IDLE.
  - SQUASH: imem_req=0; on imem_rvalid discard data, go IDLE.
  - HALTED: imem_req=0 forever; halted=1; left only via rst.
- At most one request outstanding. Issue gate uses registered count, so count never exceeds 2.
- Decode pop: instr_valid & instr_ready removes head. Push and pop in the same cycle keep count.
- Redirect has priority over everything except rst:
  - Flush FIFO (count=0); fetch_pc=redirect_pc.
  - From IDLE with no transfer, or IDLE with a transfer that cycle: go IDLE or SQUASH respectively.
  - From WAIT: SQUASH, or IDLE if imem_rvalid arrives that same cycle (data dropped).
  - A pop in the redirect cycle is still a completed handshake.
- Halt (no redirect):
  - Flush FIFO; go HALTED.
  - An outstanding response is absorbed and dropped.
  - A request unaccepted at halt is abandoned.
- Redirect and halt are ignored in HALTED.
- An unaccepted request may change address on redirect; memory must not assume stability until accepted.

## Timing

- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, count=0, state=IDLE, fetch_pc=RESET_PC.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- imem_addr = fetch_pc (registered).
- Registered path: rvalid at cycle N -> instr_valid at N+1.
- Back-to-back issue: one request per two cycles with 1-cycle memory (issue, response).
- Redirect at cycle N: instr_valid=0 at N+1; imem_req for redirect_pc at N+1 if no outstanding response.
- Halt at cycle N: halted=1 and instr_valid=0 from N+1.
- rst mid-transaction: returns to reset state next cycle; late responses from before reset are ignored while IDLE with no outstanding request.

## Configuration

- IFETCH_BYPASS_EN defined:
  - When count==0, state WAIT and imem_rvalid=1: instr_valid=1 same cycle with instr=imem_rdata and instr_pc=request address (combinational).
  - If instr_ready also high, the word is not pushed.
  - Redirect or halt in that cycle forces instr_valid=0.
- IFETCH_BYPASS_EN undefined: all outputs registered; fetch-to-decode latency is one cycle after rvalid.

## Test plan

- Reset, RESET_PC=16'h0010, memory always ready with 1-cycle rvalid returning data=addr^16'hA000, instr_ready=1 -> decode receives pc 0010,0011,0012 with instr A010,A011,A012, in order, no gaps beyond the issue rate.
- instr_ready=0 for 10 cycles -> exactly two requests issued (addr 0,1); FIFO full, imem_req=0; releasing ready delivers 0,1 then fetch resumes at 2.
- Redirect to 16'h0100 while WAIT for addr 5 -> addr-5 response dropped, FIFO empty, next request addr 0100, first delivered instr_pc=0100.
- Redirect in the same cycle as rvalid and an instr_valid&instr_ready pop -> popped instruction counted once, rvalid data dropped, next request at redirect_pc.
- Halt with one instruction buffered and one outstanding -> halted=1 next cycle; instr_valid stays 0; imem_req stays 0 for 20 cycles; redirect ignored; rst clears halted.
- fetch_pc=16'hFFFF -> next request address 16'h0000. With IFETCH_BYPASS_EN, empty FIFO + rvalid -> instr_valid same cycle.
